// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and constants for the two-master Wishbone arbiter
package wb_arb_pkg;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} arb_state_t;
endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - wait counter that flags when a strobed transfer reaches its limit
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear dominates so an ack in the expiring cycle restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == LAST);
endmodule

// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - round-robin two-master Wishbone classic arbiter with bus watchdog
module wb_arb2
    import wb_arb_pkg::*;
#(
    parameter int          AW      = 32,
    parameter int          DW      = 32,
    parameter int          SW      = DW / 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [SW-1:0] s_sel_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);
    arb_state_t state_q, state_d;
    logic       last_q, last_d;
    logic       in_gnt, own_cyc, own_stb, wd_expire, timeout;

    // last_q doubles as the owner index while granted or aborting.
    assign in_gnt  = (state_q == GNT0) || (state_q == GNT1);
    assign own_cyc = last_q ? m1_cyc_i : m0_cyc_i;
    assign own_stb = last_q ? m1_stb_i : m0_stb_i;
    assign timeout = in_gnt && own_stb && !s_ack_i && wd_expire;
    assign gnt_o   = (state_q == IDLE) ? 2'b00 : (last_q ? 2'b10 : 2'b01);

    wb_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .en     (s_cyc_o && s_stb_o && !s_ack_i),
        .clr    (!s_stb_o || s_ack_i || !in_gnt),
        .expire (wd_expire)
    );

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (in_gnt && !last_q) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_sel_o  = m0_sel_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = timeout;
            m0_dat_o = s_dat_i;
        end else if (in_gnt) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_sel_o  = m1_sel_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = timeout;
            m1_dat_o = s_dat_i;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0, GNT1: begin
                // Release wins over timeout: err still pulses, ABORT is skipped.
                if (!own_cyc) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - scoreboard bench for wb_arb2 with random masters and a latency-coded slave
module tb_wb_arb2;
    localparam int TO = 8;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        bit          is_err;
        logic [31:0] rdata;
        int          wt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic [31:0] m_rdat[2];
    logic [3:0]  m_sel [2];
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [3:0]  s_sel;
    logic [1:0]  gnt;

    int   n_chk = 0;
    int   n_fail = 0;
    rec_t sb0[$];
    rec_t sb1[$];
    int   hist[$];
    int   gaps[$];
    int   lat_tab[8] = '{0, 1, 2, 3, 5, 7, 8, 12};

    wb_arb2 #(.AW(32), .DW(32), .SW(4), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk),        .wb_rst_i(rst),
        .m0_cyc_i(m_cyc[0]),   .m0_stb_i(m_stb[0]),   .m0_we_i(m_we[0]),
        .m0_adr_i(m_adr[0]),   .m0_sel_i(m_sel[0]),   .m0_dat_i(m_wdat[0]),
        .m0_dat_o(m_rdat[0]),  .m0_ack_o(m_ack[0]),   .m0_err_o(m_err[0]),
        .m1_cyc_i(m_cyc[1]),   .m1_stb_i(m_stb[1]),   .m1_we_i(m_we[1]),
        .m1_adr_i(m_adr[1]),   .m1_sel_i(m_sel[1]),   .m1_dat_i(m_wdat[1]),
        .m1_dat_o(m_rdat[1]),  .m1_ack_o(m_ack[1]),   .m1_err_o(m_err[1]),
        .s_cyc_o(s_cyc),       .s_stb_o(s_stb),       .s_we_o(s_we),
        .s_adr_o(s_adr),       .s_sel_o(s_sel),       .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i),     .s_ack_i(s_ack),       .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave: address bits [7:4] give the number of wait clocks before ack.
    int scnt = 0;
    bit done_p = 1'b1;
    initial begin
        s_ack   = 1'b0;
        s_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst || !(s_cyc && s_stb)) begin
                scnt  = 0;
                s_ack = 1'b0;
            end else begin
                scnt  = done_p ? 0 : scnt + 1;
                s_ack = (scnt == int'(s_adr[7:4]));
            end
            s_dat_i = rdata_of(s_adr);
        end
    end

    // Monitor: spec-level grant prediction plus scoreboard pops on every response.
    logic [1:0] eg, eg_p = 2'b00;
    logic [1:0] cyc_p = 2'b00;
    bit rst_p = 1'b1, last_m = 1'b1, ab = 1'b0, errp = 1'b0, resp_p = 1'b0, act_p = 1'b0;
    int gap = 0, run = 0;
    always @(negedge clk) begin
        int   o;
        bit   act, resp;
        rec_t r;
        if (rst_p) begin
            eg     = 2'b00;
            last_m = 1'b1;
        end else if (eg_p == 2'b00) begin
            if (cyc_p[0] && cyc_p[1]) eg = last_m ? 2'b01 : 2'b10;
            else if (cyc_p[0])        eg = 2'b01;
            else if (cyc_p[1])        eg = 2'b10;
            else                      eg = 2'b00;
        end else begin
            eg = cyc_p[eg_p[1]] ? eg_p : 2'b00;
        end
        if (eg != 2'b00 && eg_p == 2'b00) begin
            last_m = eg[1];
            hist.push_back(int'(eg[1]));
            gaps.push_back(gap);
        end
        gap = (eg == 2'b00) ? gap + 1 : 0;
        if (eg == 2'b00) ab = 1'b0;
        else if (errp)   ab = 1'b1;
        chk("gnt", gnt, eg);
        o   = eg[1] ? 1 : 0;
        act = (eg != 2'b00) && !ab;
        if (eg == 2'b00 || act)
            chk("slave_bus", {s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o},
                act ? {m_cyc[o], m_stb[o], m_we[o], m_adr[o], m_sel[o], m_wdat[o]} : 71'd0);
        else
            chk("abort_bus", {s_cyc, s_stb}, 2'b00);
        for (int m = 0; m < 2; m++) begin
            if (act && m == o)           chk("owner_ack", {m_ack[m], m_rdat[m]}, {s_ack, s_dat_i});
            else if (eg != 0 && m == o)  chk("abort_resp", {m_ack[m], m_err[m]}, 2'b00);
            else                         chk("idle_resp", {m_ack[m], m_err[m], m_rdat[m]}, 34'd0);
        end
        if (s_cyc && s_stb) run = (resp_p || !act_p) ? 1 : run + 1;
        resp = act && (m_ack[o] || m_err[o]);
        if (resp) begin
            chk("ack_err_excl", {m_ack[o], m_err[o]} == 2'b11, 1'b0);
            chk("sb_depth", (o == 0) ? sb0.size() : sb1.size(), 1);
            if ((o == 0 && sb0.size() > 0) || (o == 1 && sb1.size() > 0)) begin
                r = (o == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("resp_kind", m_err[o], r.is_err);
                chk("resp_wait", run, r.wt);
                chk("resp_adr", s_adr, r.adr);
                if (r.we) chk("wdata", {s_we, s_sel, s_dat_o}, {1'b1, r.sel, r.dat});
                else if (!r.is_err) chk("rdata", m_rdat[o], r.rdata);
            end
        end
        errp   = act && m_err[o];
        resp_p = s_ack || m_err[0] || m_err[1];
        act_p  = s_cyc && s_stb;
        done_p = resp_p || !act_p;
        rst_p  = rst;
        eg_p   = eg;
        cyc_p  = m_cyc;
    end

    // lat >= 0 gives a fixed phase at adr = lat<<4; otherwise random address and latency.
    task automatic master_cycle(input int m, input int nph, input int lat, input int wmode, input int hold);
        rec_t        r;
        int          l, w;
        bit          got_err;
        logic [31:0] tmp;
        got_err = 1'b0;
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b1;
        for (int p = 0; p < nph && !got_err; p++) begin
            l    = (lat >= 0) ? lat : lat_tab[$urandom_range(0, 7)];
            r.we = (wmode == 2) ? 1'($urandom_range(0, 1)) : 1'(wmode);
            if (lat >= 0) begin
                r.adr = 32'(l) << 4;
                r.dat = 32'hDEAD_BEEF;
                r.sel = 4'hF;
            end else begin
                tmp   = $urandom();
                r.adr = {tmp[31:8], 4'(l), tmp[3:0]};
                r.dat = $urandom();
                r.sel = 4'($urandom_range(1, 15));
            end
            r.is_err = (l > TO - 1);
            r.wt     = (r.is_err ? TO - 1 : l) + 1;
            r.rdata  = rdata_of(r.adr);
            m_stb[m]  = 1'b1;
            m_we[m]   = r.we;
            m_adr[m]  = r.adr;
            m_wdat[m] = r.dat;
            m_sel[m]  = r.sel;
            if (m == 0) sb0.push_back(r);
            else        sb1.push_back(r);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!(m_ack[m] || m_err[m]) && w < 400);
            if (w >= 400) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp_bound: master %0d got no ack/err within %0d clocks", m, w);
            end
            got_err = m_err[m];
            @(posedge clk);
            #1;
        end
        m_stb[m] = 1'b0;
        if (got_err) repeat (hold) begin
            @(posedge clk);
            #1;
        end
        m_cyc[m] = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_bound: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m_cyc = 2'b11;
        m_stb = 2'b00;
        m_we  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_adr[i]  = '0;
            m_wdat[i] = '0;
            m_sel[i]  = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {gnt, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o, m_ack, m_err}, 77'd0);
        chk("rst_rdata", {m_rdat[0], m_rdat[1]}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("first_gnt", gnt, 2'b01);
        @(posedge clk);
        #1 m_cyc = 2'b00;
        repeat (2) @(posedge clk);

        master_cycle(0, 1, 4, 1, 0);
        chk("write_done", sb0.size(), 0);

        master_cycle(0, 1, 7, 0, 0);
        chk("race_done", sb0.size(), 0);

        hist.delete(); gaps.delete();
        fork
            master_cycle(1, 4, 1, 1, 0);
            begin
                repeat (2) @(posedge clk);
                master_cycle(0, 1, 2, 0, 0);
            end
        join
        chk("burst_len", hist.size(), 2);
        if (hist.size() == 2) begin
            chk("burst_own0", hist[0], 1);
            chk("burst_own1", hist[1], 0);
            chk("burst_gap", gaps[1], 1);
        end

        hist.delete(); gaps.delete();
        fork
            master_cycle(0, 1, 15, 0, 3);
            begin
                repeat (4) @(posedge clk);
                master_cycle(1, 1, 3, 1, 0);
            end
        join
        chk("tmo_len", hist.size(), 2);
        if (hist.size() == 2) begin
            chk("tmo_own0", hist[0], 0);
            chk("tmo_own1", hist[1], 1);
        end

        hist.delete(); gaps.delete();
        fork
            for (int k = 0; k < 3; k++) master_cycle(0, 1, 2, 2, 0);
            for (int k = 0; k < 3; k++) master_cycle(1, 1, 2, 2, 0);
        join
        chk("cont_len", hist.size(), 6);
        for (int i = 0; i < hist.size() && i < 6; i++) begin
            chk($sformatf("cont_own%0d", i), hist[i], i % 2);
            if (i > 0) chk($sformatf("cont_gap%0d", i), gaps[i], 1);
        end

        fork
            for (int k = 0; k < 10; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                master_cycle(0, $urandom_range(1, 3), -1, 2, $urandom_range(0, 2));
            end
            for (int k = 0; k < 10; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                master_cycle(1, $urandom_range(1, 3), -1, 2, $urandom_range(0, 2));
            end
        join

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb0_left", sb0.size(), 0);
        chk("sb1_left", sb1.size(), 0);
        chk("final_gnt", gnt, 2'b00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arb2.md
Name: wb_arb2

Overview:
- Two-master Wishbone B3 classic arbiter that shares the single Wishbone slave port of the SDRAM controller.
- Example masters: a CPU/testbench master on port 0 and a DMA master on port 1.
- Grants are round-robin and held for a whole bus cycle (cyc_i high).
- A bus watchdog terminates any transfer the slave fails to ack within TIMEOUT clocks, and signals err to the granted master.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- SW, DW/8, byte-select width.
- TIMEOUT, 256, max clocks a strobed transfer may wait for s_ack_i; legal range 2..65535.

Ports:
- wb_clk_i  in  1  Wishbone clock; single clock domain.
- wb_rst_i  in  1  reset, synchronous, active-high.
- mN_cyc_i, mN_stb_i, mN_we_i  in  1 each  master N (N=0,1) cycle, strobe, write enable.
- mN_adr_i  in  AW  master N address.
- mN_sel_i  in  SW  master N byte selects.
- mN_dat_i  in  DW  master N write data.
- mN_dat_o  out  DW  read data to master N.
- mN_ack_o, mN_err_o  out  1 each  acknowledge and error to master N.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SDRAM controller slave port.
- s_adr_o  out  AW;  s_sel_o  out  SW;  s_dat_o  out  DW.
- s_dat_i  in  DW;  s_ack_i  in  1  from the slave.
- gnt_o  out  2  one-hot current grant, debug/assertion visibility.

Behaviour:
- State machine, registered: IDLE, GNT0, GNT1, ABORT.
- Priority pointer `last` (1 bit) records the most recently granted master. Reset value 1, so master 0 wins the first tie.
- Reset: wb_rst_i high at a wb_clk_i edge forces state=IDLE, last=1, timeout counter=0.
  - While in reset and in IDLE, every output is 0: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, mN_ack_o, mN_err_o, mN_dat_o, gnt_o.
  - This satisfies Wishbone rules 3.00/3.10.
  - Reset mid-transfer drops s_cyc_o in the cycle after the reset edge; no ack or err is generated for the abandoned transfer.
- IDLE:
  - Only m0_cyc_i high -> GNT0.
  - Only m1_cyc_i high -> GNT1.
  - Both high -> grant the master != last.
  - Neither high -> stay in IDLE.
  - Grant latency is 1 clock: a request at edge k is visible on s_cyc_o after edge k+1.
- GNTn (gnt_o one-hot for n):
  - Slave outputs s_cyc_o = mn_cyc_i, s_stb_o = mn_stb_i, s_we/adr/sel/dat_o = master n, all combinational pass-through.
  - mn_ack_o = s_ack_i and mn_dat_o = s_dat_i, combinational.
  - The non-granted master sees ack=0, err=0, dat_o=0.
  - Entering GNTn sets last=n.
- Release: in GNTn with mn_cyc_i=0 at an edge -> IDLE. There is one dead cycle between ownerships, which guarantees s_cyc_o low for at least 1 clock between masters.
- Watchdog:
  - 16-bit counter; cleared when s_stb_o=0, when s_ack_i=1, or in IDLE/ABORT.
  - Increments while s_cyc_o & s_stb_o & !s_ack_i.
  - When the counter equals TIMEOUT-1 and s_ack_i=0:
    - mn_err_o pulses for exactly 1 clock, combinational in that cycle.
    - Next state is ABORT.
- ABORT:
  - s_cyc_o = s_stb_o = 0; gnt_o keeps the aborted master; all mN_ack/err = 0.
  - Stays until mn_cyc_i=0, then -> IDLE.
- Simultaneous events:
  - s_ack_i and timeout in the same cycle -> ack wins; no err, counter clears.
  - Master drops cyc in the same cycle as the timeout -> err is still pulsed, next state is IDLE (ABORT is skipped).
- Ack and err are never both high to the same master.
- Block/burst cycles: the grant holds across multiple stb phases while cyc stays high; the counter restarts per transfer.

Decomposition:
- Package wb_arb_pkg:
  - state enum arb_state_t {IDLE, GNT0, GNT1, ABORT};
  - localparam CNT_W=16.
- Sub-module wb_watchdog (counter plus compare; ports clk, rst, en, clr, expire) is natural and reusable for other Wishbone slaves.
- The mux and FSM stay in wb_arb2.

Test Plan:
- Reset: wb_rst_i=1 for 3 clocks with both masters requesting -> all outputs 0, gnt_o=2'b00. First clock after release -> gnt_o=2'b01.
- Single write: m0 writes adr=0x0000_0040, dat=0xDEADBEEF, sel=4'hF; slave acks after 5 clocks -> s_* match master 0, m0_ack_o high for 1 clock, m1_ack_o stays 0.
- Contention: m0 and m1 assert cyc on the same edge, each doing 3 back-to-back cycles.
  - Required grant sequence: 01,10,01,10,01,10.
  - s_cyc_o is low for exactly 1 clock between owners.
- Burst hold: m1 holds cyc for 4 stb transfers while m0 requests -> gnt_o stays 10 until m1_cyc_i falls, then m0 is granted 2 clocks later.
- Timeout: TIMEOUT=8, slave never acks a m0 read.
  - m0_err_o pulses on the 8th clock of stb, s_cyc_o drops the next clock.
  - gnt_o stays 01 until m0_cyc_i=0, after which m1 can be granted.
- Ack/timeout race: s_ack_i asserted exactly on the TIMEOUT-1 count -> m0_ack_o=1, m0_err_o=0, no ABORT.
